lcd_text_feeder: RTL and testbench

- Upstream stage of lcd_ctrl. Accepts ASCII bytes from the CPU-side bus over a valid/ready handshake and buffers them in a FIFO.
- Tracks the cursor of a COLS x 2 character display and turns each byte into LCD command/data requests (rs, byte) for the byte-writer handshake.
- Inserts set-DDRAM-address commands on line wrap and newline, and a clear command on form feed.
- Issues nothing until init_done from lcd_ctrl is high.

---
 rtl/lcd_text_feeder.sv | 248 ++++++++++++++++++++++++
 tb/tb_lcd_text_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_feeder.sv
// lcd_text_feeder: buffers ASCII bytes and turns them into LCD command/data requests for a COLS x 2 display.
// Latency: a byte pushed into an empty FIFO at edge N raises lcd_req after edge N+2; one printable char per 3 cycles.
// Backpressure: in_ready drops when the FIFO is full (overflowing bytes are dropped, sticky overflow); requests hold until lcd_ack.
// Optional feature macro LCD_AUTOCLEAR_EN: clear the display before the first character after a row1->row0 wrap.
module lcd_text_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int COLS       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  input  logic                          init_done,
  output logic                          lcd_req,
  output logic                          lcd_rs,
  output logic [7:0]                    lcd_byte,
  input  logic                          lcd_ack,
  output logic [5:0]                    cursor_col,
  output logic                          cursor_row,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_CLR,
    ST_ADDR,
    ST_DATA
  } state_t;

  // FIFO storage and pointers
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;
  logic          push, pop;
  logic [7:0]    fifo_head;

  // FSM and cursor state
  state_t        state_q;
  logic [7:0]    cur_q;
  logic [5:0]    col_q;
  logic          row_q;
  logic          wrap_q;
  logic          req_q, rs_q;
  logic [7:0]    byte_q;
`ifdef LCD_AUTOCLEAR_EN
  logic          autoclr_q;
`endif

  // Derived decode of the current byte and cursor addresses
  logic          cur_printable;
  logic          last_col;
  logic [7:0]    addr_here;
  logic [7:0]    addr_newline;

  assign in_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == ST_IDLE) && (count_q != '0) && init_done;
  assign fifo_head  = mem_q[rd_ptr_q];

  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != ST_IDLE);
  assign lcd_req    = req_q;
  assign lcd_rs     = rs_q;
  assign lcd_byte   = byte_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  // Classify the dispatched byte and precompute set-DDRAM-address commands
  always_comb begin
    cur_printable = (cur_q >= 8'h20) && (cur_q <= 8'h7E);
    last_col      = (col_q == 6'(COLS - 1));
    addr_here     = 8'h80 | ((row_q ? 8'h40 : 8'h00) + {2'b00, col_q});
    // newline without a pending wrap lands at column 0 of the other row
    addr_newline  = row_q ? 8'h80 : 8'hC0;
  end

  // Next FIFO occupancy from simultaneous push/pop
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO data array, no reset needed since pointers gate every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (in_valid && !in_ready) overflow_q <= 1'b1;
    end
  end

  // Character dispatch FSM with registered request outputs and cursor tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= 8'h00;
      col_q     <= 6'd0;
      row_q     <= 1'b0;
      wrap_q    <= 1'b0;
      req_q     <= 1'b0;
      rs_q      <= 1'b0;
      byte_q    <= 8'h00;
`ifdef LCD_AUTOCLEAR_EN
      autoclr_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            cur_q   <= fifo_head;
            state_q <= ST_DISPATCH;
          end
        end

        ST_DISPATCH: begin
          if (cur_q == 8'h0C) begin
            req_q   <= 1'b1;
            rs_q    <= 1'b0;
            byte_q  <= 8'h01;
            state_q <= ST_CLR;
          end else if (cur_q == 8'h0A) begin
            // a newline right after a line wrap only consumes the wrap
            if (wrap_q) begin
              wrap_q <= 1'b0;
              byte_q <= addr_here;
            end else begin
              col_q  <= 6'd0;
              row_q  <= ~row_q;
              byte_q <= addr_newline;
`ifdef LCD_AUTOCLEAR_EN
              if (row_q) autoclr_q <= 1'b1;
`endif
            end
            req_q   <= 1'b1;
            rs_q    <= 1'b0;
            state_q <= ST_ADDR;
          end else if (cur_printable) begin
`ifdef LCD_AUTOCLEAR_EN
            if (autoclr_q) begin
              req_q   <= 1'b1;
              rs_q    <= 1'b0;
              byte_q  <= 8'h01;
              state_q <= ST_CLR;
            end else
`endif
            if (wrap_q) begin
              req_q   <= 1'b1;
              rs_q    <= 1'b0;
              byte_q  <= addr_here;
              state_q <= ST_ADDR;
            end else begin
              req_q   <= 1'b1;
              rs_q    <= 1'b1;
              byte_q  <= cur_q;
              state_q <= ST_DATA;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_CLR: begin
          if (lcd_ack) begin
            col_q  <= 6'd0;
            row_q  <= 1'b0;
            wrap_q <= 1'b0;
`ifdef LCD_AUTOCLEAR_EN
            autoclr_q <= 1'b0;
            // an automatic clear continues with the character that triggered it
            if (autoclr_q && cur_printable) begin
              rs_q    <= 1'b1;
              byte_q  <= cur_q;
              state_q <= ST_DATA;
            end else begin
              req_q   <= 1'b0;
              state_q <= ST_IDLE;
            end
`else
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
`endif
          end
        end

        ST_ADDR: begin
          if (lcd_ack) begin
            wrap_q <= 1'b0;
            if (cur_printable) begin
              rs_q    <= 1'b1;
              byte_q  <= cur_q;
              state_q <= ST_DATA;
            end else begin
              req_q   <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end

        ST_DATA: begin
          if (lcd_ack) begin
            if (last_col) begin
              col_q  <= 6'd0;
              row_q  <= ~row_q;
              wrap_q <= 1'b1;
`ifdef LCD_AUTOCLEAR_EN
              if (row_q) autoclr_q <= 1'b1;
`endif
            end else begin
              col_q <= col_q + 6'd1;
            end
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Directed bench for lcd_text_feeder: reset, init gating, latency, throughput, wrap, newline, clear, backpressure, mid-transfer reset.
module tb_lcd_text_feeder;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       init_done = 1'b0;
  logic       lcd_req, lcd_rs;
  logic [7:0] lcd_byte;
  logic       lcd_ack = 1'b1;
  logic [5:0] cursor_col;
  logic       cursor_row;
  logic [4:0] fifo_count;
  logic       busy, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cycles = 0;
  logic [8:0] xfer_q [$];

  lcd_text_feeder #(.FIFO_DEPTH(DEPTH), .COLS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .init_done(init_done), .lcd_req(lcd_req), .lcd_rs(lcd_rs), .lcd_byte(lcd_byte),
    .lcd_ack(lcd_ack), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .fifo_count(fifo_count), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Log every transfer that will complete at the next rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (lcd_req) req_cycles++;
      if (lcd_req && lcd_ack) xfer_q.push_back({lcd_rs, lcd_byte});
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    xfer_q.delete();
    req_cycles = 0;
  endtask

  // Offer one byte for exactly one edge, regardless of in_ready
  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      #1 cyc++;
      if (fifo_count == 0 && !busy) break;
    end
    n_checks++;
    if (cyc >= 300) begin n_fail++; $display("FAIL wait_idle: timed out, fifo_count=%0d busy=%b required 0/0", fifo_count, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++; if (lcd_req !== 1'b0)    begin n_fail++; $display("FAIL reset_req: got %b want 0", lcd_req); end
    n_checks++; if (lcd_rs !== 1'b0)     begin n_fail++; $display("FAIL reset_rs: got %b want 0", lcd_rs); end
    n_checks++; if (lcd_byte !== 8'h00)  begin n_fail++; $display("FAIL reset_byte: got %h want 00", lcd_byte); end
    n_checks++; if ({cursor_row, cursor_col} !== 7'd0) begin n_fail++; $display("FAIL reset_cursor: got %0d/%0d want 0/0", cursor_row, cursor_col); end
    n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_init_gate();
    do_reset();
    init_done = 1'b0;
    lcd_ack = 1'b1;
    push(8'h41);
    push(8'h42);
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (req_cycles != 0)     begin n_fail++; $display("FAIL gate_no_req: got %0d request cycles want 0", req_cycles); end
    n_checks++; if (fifo_count !== 5'd2) begin n_fail++; $display("FAIL gate_count: got %0d want 2", fifo_count); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL gate_busy: got %b want 0", busy); end
    init_done = 1'b1;
    wait_idle();
    n_checks++; if (xfer_q.size() != 2)  begin n_fail++; $display("FAIL gate_nxfer: got %0d want 2", xfer_q.size()); end
    else begin
      n_checks++; if (xfer_q[0] !== 9'h141) begin n_fail++; $display("FAIL gate_x0: got %h want 141", xfer_q[0]); end
      n_checks++; if (xfer_q[1] !== 9'h142) begin n_fail++; $display("FAIL gate_x1: got %h want 142", xfer_q[1]); end
    end
    n_checks++; if (cursor_col !== 6'd2) begin n_fail++; $display("FAIL gate_col: got %0d want 2", cursor_col); end
  endtask

  task automatic test_latency();
    do_reset();
    init_done = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h51;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (lcd_req !== 1'b0) begin n_fail++; $display("FAIL lat_n0: got %b want 0", lcd_req); end
    @(negedge clk);
    n_checks++; if (lcd_req !== 1'b0) begin n_fail++; $display("FAIL lat_n1: got %b want 0", lcd_req); end
    @(negedge clk);
    n_checks++; if ({lcd_req, lcd_rs, lcd_byte} !== 10'h351) begin n_fail++; $display("FAIL lat_n2: got req=%b rs=%b byte=%h want 1/1/51", lcd_req, lcd_rs, lcd_byte); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    do_reset();
    init_done = 1'b0;
    push(8'h61);
    push(8'h62);
    push(8'h63);
    xfer_q.delete();
    init_done = 1'b1;
    while (xfer_q.size() < 3 && cyc < 50) begin
      @(negedge clk);
      #1 cyc++;
    end
    n_checks++; if (cyc != 9) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 9", cyc); end
    n_checks++; if (xfer_q.size() != 3 || xfer_q[2] !== 9'h163) begin n_fail++; $display("FAIL b2b_last: got n=%0d want 3 ending 163", xfer_q.size()); end
    wait_idle();
  endtask

  task automatic test_wrap();
    do_reset();
    init_done = 1'b1;
    lcd_ack = 1'b1;
    for (int i = 0; i < 17; i++) push(8'h78);
    push(8'h79);
    wait_idle();
    n_checks++; if (xfer_q.size() != 19) begin n_fail++; $display("FAIL wrap_nxfer: got %0d want 19", xfer_q.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        n_checks++; if (xfer_q[i] !== 9'h178) begin n_fail++; $display("FAIL wrap_data%0d: got %h want 178", i, xfer_q[i]); end
      end
      n_checks++; if (xfer_q[16] !== 9'h0C0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0C0", xfer_q[16]); end
      n_checks++; if (xfer_q[17] !== 9'h178) begin n_fail++; $display("FAIL wrap_x17: got %h want 178", xfer_q[17]); end
      n_checks++; if (xfer_q[18] !== 9'h179) begin n_fail++; $display("FAIL wrap_y: got %h want 179", xfer_q[18]); end
    end
    n_checks++; if ({cursor_row, cursor_col} !== {1'b1, 6'd2}) begin n_fail++; $display("FAIL wrap_cursor: got %0d/%0d want 1/2", cursor_row, cursor_col); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_newline();
    do_reset();
    init_done = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h61);
    push(8'h0A);
    push(8'h7A);
    wait_idle();
    n_checks++; if (xfer_q.size() != 18) begin n_fail++; $display("FAIL nl_nxfer: got %0d want 18", xfer_q.size()); end
    else begin
      n_checks++; if (xfer_q[16] !== 9'h0C0) begin n_fail++; $display("FAIL nl_addr: got %h want 0C0", xfer_q[16]); end
      n_checks++; if (xfer_q[17] !== 9'h17A) begin n_fail++; $display("FAIL nl_z: got %h want 17A", xfer_q[17]); end
    end
    n_checks++; if ({cursor_row, cursor_col} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL nl_cursor: got %0d/%0d want 1/1", cursor_row, cursor_col); end
    // plain newline on row 1 goes back to row 0 column 0
    xfer_q.delete();
    push(8'h0A);
    wait_idle();
    n_checks++; if (xfer_q.size() != 1 || xfer_q[0] !== 9'h080) begin n_fail++; $display("FAIL nl_row0: got n=%0d want one 080", xfer_q.size()); end
    n_checks++; if ({cursor_row, cursor_col} !== 7'd0) begin n_fail++; $display("FAIL nl_row0_cursor: got %0d/%0d want 0/0", cursor_row, cursor_col); end
  endtask

  task automatic test_clear_and_ctrl();
    do_reset();
    init_done = 1'b1;
    push(8'h48);
    push(8'h49);
    push(8'h0C);
    wait_idle();
    n_checks++; if (xfer_q.size() != 3 || xfer_q[2] !== 9'h001) begin n_fail++; $display("FAIL clr_cmd: got n=%0d want 3 ending 001", xfer_q.size()); end
    n_checks++; if ({cursor_row, cursor_col} !== 7'd0) begin n_fail++; $display("FAIL clr_cursor: got %0d/%0d want 0/0", cursor_row, cursor_col); end
    xfer_q.delete();
    push(8'h07);
    wait_idle();
    n_checks++; if (xfer_q.size() != 0) begin n_fail++; $display("FAIL bel_noxfer: got %0d want 0", xfer_q.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bel_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    init_done = 1'b1;
    lcd_ack = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) push(8'h30 + 8'(i));
    n_checks++; if (fifo_count !== 5'(DEPTH)) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", fifo_count, DEPTH); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b want 1", overflow); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if ({lcd_req, lcd_rs, lcd_byte} !== 10'h330) begin n_fail++; $display("FAIL bp_hold: got req=%b rs=%b byte=%h want 1/1/30", lcd_req, lcd_rs, lcd_byte); end
    n_checks++; if (fifo_count !== 5'(DEPTH)) begin n_fail++; $display("FAIL bp_count_hold: got %0d want %0d", fifo_count, DEPTH); end
  endtask

  task automatic test_reset_midtransfer();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (lcd_req !== 1'b0)    begin n_fail++; $display("FAIL rstmid_req: got %b want 0", lcd_req); end
    n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
    n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    lcd_ack = 1'b1;
    req_cycles = 0;
    xfer_q.delete();
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (req_cycles != 0 || xfer_q.size() != 0) begin n_fail++; $display("FAIL rstmid_spurious: got %0d request cycles want 0", req_cycles); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_latency();
    test_back_to_back();
    test_wrap();
    test_newline();
    test_clear_and_ctrl();
    test_backpressure();
    test_reset_midtransfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
